// File: rtl/gray_monitor_pkg.sv
// Shared encodings for the gray counter monitor.
// State and fault-code constants used by the monitor and its bench.
package gray_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_STEP = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;

endpackage

// File: rtl/gray_monitor_g2b.sv
// Combinational gray-to-binary converter.
// Bit i of the binary value is the XOR of all gray bits at or above i.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    always_comb begin
        binary = '0;
        for (int i = 0; i < WIDTH; i++) begin
            binary[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_monitor.sv
// Monitor for the gray counter stage: checks single steps and wraps,
// counts wraps and cross-checks the counter's sticky overflow flag.
module gray_monitor
    import gray_monitor_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clr,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  Gray,
    input  logic              Ovf_in,
    output logic [WIDTH-1:0]  Binary,
    output logic              Step,
    output logic              Wrap,
    output logic [WRAP_W-1:0] Wrap_cnt,
    output logic              Error,
    output logic [1:0]        Err_code,
    output logic [1:0]        State
);

    state_t             st;
    logic [WIDTH-1:0]   last;
    logic [WIDTH-1:0]   bin_new;
    logic [WIDTH-1:0]   delta;
    logic               at_max;
    logic               is_step;
    logic               is_wrap;
    logic               is_rep;
    logic               bad_step;
    logic               bad_ovf;
    logic [WRAP_W-1:0]  wrap_next;
    logic [1:0]         err_next;

    gray2bin #(.WIDTH(WIDTH)) u_g2b (
        .gray   (Gray),
        .binary (bin_new)
    );

    always_comb begin
        delta     = bin_new - last;
        at_max    = (last == '1);
        is_rep    = (delta == '0);
        is_step   = (delta == WIDTH'(1)) && !at_max;
        is_wrap   = at_max && (bin_new == '0);
        bad_step  = !(is_rep || is_step || is_wrap);
        wrap_next = Wrap_cnt;
        if (is_wrap && !(&Wrap_cnt)) begin
            wrap_next = Wrap_cnt + WRAP_W'(1);
        end
        // Overflow is sticky, so it must agree with "any wrap seen yet".
        bad_ovf   = Ovf_in ? (wrap_next == '0) : (wrap_next != '0);
        err_next  = (bad_step ? ERR_STEP : ERR_NONE)
                  | (bad_ovf  ? ERR_OVF  : ERR_NONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            st       <= ST_IDLE;
            last     <= '0;
            Binary   <= '0;
            Step     <= 1'b0;
            Wrap     <= 1'b0;
            Wrap_cnt <= '0;
            Error    <= 1'b0;
            Err_code <= ERR_NONE;
        end else begin
            Step <= 1'b0;
            Wrap <= 1'b0;
            if (Clr) begin
                st       <= ST_IDLE;
                last     <= '0;
                Binary   <= '0;
                Wrap_cnt <= '0;
                Error    <= 1'b0;
                Err_code <= ERR_NONE;
            end else if (Valid) begin
                unique case (st)
                    ST_IDLE: begin
                        Binary <= bin_new;
                        last   <= bin_new;
                        st     <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        Binary <= bin_new;
                        if (err_next != ERR_NONE) begin
                            Error    <= 1'b1;
                            Err_code <= err_next;
                            st       <= ST_FAULT;
                        end else begin
                            last     <= bin_new;
                            Step     <= is_step;
                            Wrap     <= is_wrap;
                            Wrap_cnt <= wrap_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign State = st;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor with hand-computed expectations.
// Each check is an immediate assertion that counts its failures.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Clr;
    logic       Valid;
    logic [2:0] Gray;
    logic       Ovf_in;
    logic [2:0] Binary;
    logic       Step;
    logic       Wrap;
    logic [7:0] Wrap_cnt;
    logic       Error;
    logic [1:0] Err_code;
    logic [1:0] State;

    int total = 0;
    int bad   = 0;

    // Gray code for binary 0..7.
    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

    gray_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clr      (Clr),
        .Valid    (Valid),
        .Gray     (Gray),
        .Ovf_in   (Ovf_in),
        .Binary   (Binary),
        .Step     (Step),
        .Wrap     (Wrap),
        .Wrap_cnt (Wrap_cnt),
        .Error    (Error),
        .Err_code (Err_code),
        .State    (State)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] g,
                         input logic ovf, input logic clr);
        @(negedge Clk);
        Valid  = v;
        Gray   = g;
        Ovf_in = ovf;
        Clr    = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bin"},   32'(Binary),   32'd0);
        check({tag, "_step"},  32'(Step),     32'd0);
        check({tag, "_wrap"},  32'(Wrap),     32'd0);
        check({tag, "_wcnt"},  32'(Wrap_cnt), 32'd0);
        check({tag, "_err"},   32'(Error),    32'd0);
        check({tag, "_code"},  32'(Err_code), 32'd0);
        check({tag, "_state"}, 32'(State),    32'd0);
    endtask

    initial begin
        Reset  = 1'b0;
        Clr    = 1'b0;
        Valid  = 1'b0;
        Gray   = 3'b000;
        Ovf_in = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_zero("reset");
        @(negedge Clk);
        Reset = 1'b1;

        // Reference then seven legal steps.
        drive(1'b1, gseq[0], 1'b0, 1'b0);
        check("ref_bin",   32'(Binary), 32'd0);
        check("ref_step",  32'(Step),   32'd0);
        check("ref_state", 32'(State),  32'd1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, gseq[i], 1'b0, 1'b0);
            check("seq_bin",  32'(Binary), 32'(i));
            check("seq_step", 32'(Step),   32'd1);
        end
        check("seq_err",   32'(Error), 32'd0);
        check("seq_state", 32'(State), 32'd1);

        // Wrap with overflow raised, then a step.
        drive(1'b1, 3'b000, 1'b1, 1'b0);
        check("wrap_pulse", 32'(Wrap),     32'd1);
        check("wrap_step",  32'(Step),     32'd0);
        check("wrap_cnt",   32'(Wrap_cnt), 32'd1);
        check("wrap_bin",   32'(Binary),   32'd0);
        drive(1'b1, 3'b001, 1'b1, 1'b0);
        check("post_step", 32'(Step),  32'd1);
        check("post_wrap", 32'(Wrap),  32'd0);
        check("post_err",  32'(Error), 32'd0);

        // Idle cycle drops pulses; repeat sample is quiet.
        drive(1'b0, 3'b001, 1'b1, 1'b0);
        check("idle_step", 32'(Step),   32'd0);
        check("idle_bin",  32'(Binary), 32'd1);
        drive(1'b1, 3'b001, 1'b1, 1'b0);
        check("rep_step",  32'(Step),  32'd0);
        check("rep_state", 32'(State), 32'd1);

        // Illegal jump 2 -> 6.
        drive(1'b1, 3'b011, 1'b1, 1'b0);
        check("to2_bin", 32'(Binary), 32'd2);
        drive(1'b1, 3'b101, 1'b1, 1'b0);
        check("ill_err",   32'(Error),    32'd1);
        check("ill_code",  32'(Err_code), 32'd1);
        check("ill_state", 32'(State),    32'd2);
        check("ill_bin",   32'(Binary),   32'd6);
        check("ill_step",  32'(Step),     32'd0);
        check("ill_wcnt",  32'(Wrap_cnt), 32'd1);
        drive(1'b1, 3'b100, 1'b1, 1'b0);
        check("flt_bin",   32'(Binary),   32'd6);
        check("flt_step",  32'(Step),     32'd0);
        check("flt_code",  32'(Err_code), 32'd1);
        check("flt_state", 32'(State),    32'd2);

        // Overflow mismatch: flag set with no wrap seen.
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        check_zero("clr1");
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 1'b1, 1'b0);
        check("ovf_code",  32'(Err_code), 32'd2);
        check("ovf_err",   32'(Error),    32'd1);
        check("ovf_state", 32'(State),    32'd2);
        check("ovf_bin",   32'(Binary),   32'd1);

        // Both faults in one sample: jump 0 -> 3 with overflow set.
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 1'b1, 1'b0);
        check("both_code", 32'(Err_code), 32'd3);

        // Clr wins over Valid in the same cycle.
        drive(1'b1, 3'b011, 1'b0, 1'b1);
        check_zero("clrv");
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        check("clrv_ref_bin",   32'(Binary), 32'd4);
        check("clrv_ref_step",  32'(Step),   32'd0);
        check("clrv_ref_wrap",  32'(Wrap),   32'd0);
        check("clrv_ref_state", 32'(State),  32'd1);

        // Wrap counter saturation.
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        for (int w = 0; w < 260; w++) begin
            for (int k = 1; k < 8; k++) begin
                drive(1'b1, gseq[k], (w > 0), 1'b0);
            end
            drive(1'b1, 3'b000, 1'b1, 1'b0);
            if (w == 254) begin
                check("sat_255", 32'(Wrap_cnt), 32'd255);
            end
        end
        check("sat_cnt",   32'(Wrap_cnt), 32'd255);
        check("sat_wrap",  32'(Wrap),     32'd1);
        check("sat_err",   32'(Error),    32'd0);
        check("sat_state", 32'(State),    32'd1);

        // Async reset between edges.
        drive(1'b1, 3'b001, 1'b1, 1'b0);
        check("pre_rst_step", 32'(Step), 32'd1);
        Valid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        check_zero("async");
        @(negedge Clk);
        Reset = 1'b1;
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        check("rst_ref_bin",   32'(Binary), 32'd3);
        check("rst_ref_step",  32'(Step),   32'd0);
        check("rst_ref_state", 32'(State),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_monitor.md
Name: gray_monitor

Overview:
Downstream consumer of the 3-bit gray counter stage. It samples the counter's gray output and overflow flag on a qualifier strobe, converts gray to binary and checks that every advance is a legal single step. It counts wrap-arounds, cross-checks the counter's sticky overflow flag, and latches the first fault for software or bench inspection.

Parameters:
WIDTH, 3, width of the gray and binary code
WRAP_W, 8, width of the wrap counter (saturating)

Ports:
Clk  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately
Clr  input  1  synchronous clear: returns to IDLE, clears counters and error
Valid  input  1  Gray and Ovf_in are meaningful this cycle; driven with the counter's En delayed one cycle
Gray  input  WIDTH  gray code from the counter stage
Ovf_in  input  1  counter's sticky overflow flag
Binary  output  WIDTH  registered binary value of the last accepted sample
Step  output  1  one-cycle pulse: legal +1 step accepted
Wrap  output  1  one-cycle pulse: legal max->0 step accepted
Wrap_cnt  output  WRAP_W  wraps seen since reset/Clr; saturates at all-ones
Error  output  1  sticky fault flag
Err_code  output  2  00 none, 01 illegal step, 10 overflow mismatch, 11 both in same sample
State  output  2  00 IDLE, 01 TRACK, 10 FAULT

Behaviour:
- Reset low (async): State=IDLE; Binary=0, Step=0, Wrap=0, Wrap_cnt=0, Error=0, Err_code=00. Internal last-value register = 0.
- Conversion is combinational: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Results are registered.
- All outputs are registered and change on the edge that samples Valid=1. Step and Wrap are high for exactly the following cycle.
- Priority each edge: Clr > Valid. Clr=1 forces IDLE and clears Binary, Wrap_cnt, Error and Err_code. A Valid sample in the same cycle is dropped.
- IDLE, Valid=1: accept the sample as reference with no step check. Binary=new, last=new, go to TRACK. No Step or Wrap pulse.
- TRACK, Valid=1: compute delta = (new - last) mod 2^WIDTH.
  - delta=0: repeat; no pulse, no state change.
  - delta=1 and last != 2^WIDTH-1: Step=1, Binary=last=new.
  - last = 2^WIDTH-1 and new = 0: Wrap=1, Wrap_cnt+1 (held at all-ones if already saturated), Binary=last=new.
  - any other delta: illegal step, Err_code bit0=1.
- Overflow cross-check in TRACK uses the post-update wrap count W':
  - Ovf_in=1 with W'=0 is a mismatch.
  - Ovf_in=0 with W'>0 is a mismatch.
  - A mismatch sets Err_code bit1=1.
  - The counter raises Overflow on the same edge it wraps to 0, so the wrap sample carries Ovf_in=1 and W'=1. That is legal.
- Any error bit set: Error=1, State=FAULT. Binary holds the offending value. Wrap_cnt and last do not update.
- FAULT: all Valid samples are ignored. Error and Err_code hold until Clr or Reset.
- Valid=0: no state change. Pulses drop to 0.
- Reset asserted mid-sequence: immediate return to reset values. The next Valid is treated as an IDLE reference.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_TRACK, ST_FAULT) and Err_code constants (ERR_NONE, ERR_STEP, ERR_OVF).
- One sub-module: gray2bin, a parameterised WIDTH-bit combinational converter. The FSM, delta check and counters stay in gray_monitor.

Test Plan:
- Reset low, then high; feed Gray 000,001,011,010,110,111,101,100 with Valid=1 and Ovf_in=0 -> Binary 0..7. The first sample gives no pulse, then Step pulses 7 times, Error=0, State=01.
- Continue with Gray 000 and Ovf_in=1, then 001 with Ovf_in=1 -> Wrap pulse once, Wrap_cnt=1, then one Step. Error stays 0.
- From Binary=2 (Gray 011), feed Gray 101 (binary 6) -> Error=1, Err_code=01, State=10, Binary=6. A further legal Gray 100 is ignored.
- In TRACK with Wrap_cnt=0, feed Gray 001 after 000 with Ovf_in=1 -> Err_code=10, Error=1, State=10.
- Clr=1 with Valid=1 in the same cycle -> State=00, Wrap_cnt=0, Error=0, sample dropped. The next Valid with Gray 110 gives Binary=4 and no pulse.
- Run 256+ wraps with WRAP_W=8 -> Wrap_cnt stops at 255. Pull Reset low mid-cycle, async -> all outputs 0 before the next Clk edge.
